// File: rtl/mathb_mac_seq.sv
// Job sequencer for the math block MAC array: streams TPRAM operand/coefficient
// pairs into the MAC, waits out the output pipeline and hands the result over valid/ready.
module mathb_mac_seq #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              EFPGA2MATHB_CLK,
    input  logic              acc_ff_rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] oper_base,
    input  logic [ADDR_W-1:0] coef_base,
    input  logic [1:0]        cfg_dataout_sel,
    input  logic [5:0]        cfg_mac_out_sel,
    input  logic              cfg_sat,
    input  logic              cfg_rnd,
    input  logic              cfg_tc,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              tpram_ren,
    output logic [ADDR_W-1:0] oper_raddr,
    output logic [ADDR_W-1:0] coef_raddr,
    output logic              mathb_clk_en,
    output logic              mathb_acc_clear,
    output logic              mathb_acc_sat,
    output logic              mathb_acc_rnd,
    output logic              mathb_tc,
    output logic [5:0]        mathb_mac_out_sel,
    output logic [1:0]        mathb_dataout_sel,
    output logic              mathb_oper_sel,
    output logic              mathb_coef_sel,
    input  logic [31:0]       mathb_mac_out
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, WAIT1, WAIT2, HOLD} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
    logic [ADDR_W-1:0] oper_base_q, oper_base_d, coef_base_q, coef_base_d;
    logic [ADDR_W-1:0] oper_raddr_q, oper_raddr_d, coef_raddr_q, coef_raddr_d;
    logic              busy_q, busy_d, done_q, done_d, result_valid_q, result_valid_d;
    logic              ren_q, ren_d, clk_en_q, clk_en_d, acc_clear_q, acc_clear_d;
    logic              sat_q, sat_d, rnd_q, rnd_d, tc_q, tc_d, sel_q, sel_d;
    logic [5:0]        mos_q, mos_d;
    logic [1:0]        ds_q, ds_d;
    logic [31:0]       result_q, result_d;
    logic              to_idle;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        oper_base_d    = oper_base_q;
        coef_base_d    = coef_base_q;
        oper_raddr_d   = oper_raddr_q;
        coef_raddr_d   = coef_raddr_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        result_valid_d = result_valid_q;
        result_d       = result_q;
        ren_d          = ren_q;
        clk_en_d       = clk_en_q;
        acc_clear_d    = 1'b0;
        sat_d          = sat_q;
        rnd_d          = rnd_q;
        tc_d           = tc_q;
        sel_d          = sel_q;
        mos_d          = mos_q;
        ds_d           = ds_q;
        to_idle        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && len != '0) begin
                    state_d      = CLEAR;
                    len_d        = len;
                    idx_d        = LEN_W'(1);
                    oper_base_d  = oper_base;
                    coef_base_d  = coef_base;
                    oper_raddr_d = oper_base;
                    coef_raddr_d = coef_base;
                    busy_d       = 1'b1;
                    ren_d        = 1'b1;
                    clk_en_d     = 1'b1;
                    acc_clear_d  = 1'b1;
                    sel_d        = 1'b1;
                    sat_d        = cfg_sat;
                    rnd_d        = cfg_rnd;
                    tc_d         = cfg_tc;
                    mos_d        = cfg_mac_out_sel;
                    ds_d         = cfg_dataout_sel;
                end
            end
            // idx_q holds the index to be issued next; once it reaches len every pair has been read.
            CLEAR, RUN: begin
                if (idx_q == len_q) begin
                    state_d = DRAIN;
                    ren_d   = 1'b0;
                end else begin
                    state_d      = RUN;
                    oper_raddr_d = oper_base_q + ADDR_W'(idx_q);
                    coef_raddr_d = coef_base_q + ADDR_W'(idx_q);
                    idx_d        = idx_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                state_d  = WAIT1;
                clk_en_d = 1'b0;
                sel_d    = 1'b0;
            end
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                state_d        = HOLD;
                result_d       = mathb_mac_out;
                result_valid_d = 1'b1;
                done_d         = 1'b1;
                busy_d         = 1'b0;
            end
            HOLD: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    to_idle        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q inside {CLEAR, RUN, DRAIN, WAIT1, WAIT2}) begin
            to_idle = 1'b1;
        end

        if (to_idle) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            ren_d       = 1'b0;
            clk_en_d    = 1'b0;
            acc_clear_d = 1'b0;
            sel_d       = 1'b0;
            sat_d       = 1'b0;
            rnd_d       = 1'b0;
            tc_d        = 1'b0;
            mos_d       = '0;
            ds_d        = '0;
        end
    end

    always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            state_q        <= IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            oper_base_q    <= '0;
            coef_base_q    <= '0;
            oper_raddr_q   <= '0;
            coef_raddr_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            ren_q          <= 1'b0;
            clk_en_q       <= 1'b0;
            acc_clear_q    <= 1'b0;
            sat_q          <= 1'b0;
            rnd_q          <= 1'b0;
            tc_q           <= 1'b0;
            sel_q          <= 1'b0;
            mos_q          <= '0;
            ds_q           <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            oper_base_q    <= oper_base_d;
            coef_base_q    <= coef_base_d;
            oper_raddr_q   <= oper_raddr_d;
            coef_raddr_q   <= coef_raddr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            ren_q          <= ren_d;
            clk_en_q       <= clk_en_d;
            acc_clear_q    <= acc_clear_d;
            sat_q          <= sat_d;
            rnd_q          <= rnd_d;
            tc_q           <= tc_d;
            sel_q          <= sel_d;
            mos_q          <= mos_d;
            ds_q           <= ds_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign result            = result_q;
    assign result_valid      = result_valid_q;
    assign tpram_ren         = ren_q;
    assign oper_raddr        = oper_raddr_q;
    assign coef_raddr        = coef_raddr_q;
    assign mathb_clk_en      = clk_en_q;
    assign mathb_acc_clear   = acc_clear_q;
    assign mathb_acc_sat     = sat_q;
    assign mathb_acc_rnd     = rnd_q;
    assign mathb_tc          = tc_q;
    assign mathb_mac_out_sel = mos_q;
    assign mathb_dataout_sel = ds_q;
    assign mathb_oper_sel    = sel_q;
    assign mathb_coef_sel    = sel_q;

endmodule

// File: tb/tb_mathb_mac_seq.sv
// Randomised scoreboard bench for mathb_mac_seq with behavioural TPRAM and MAC stand-ins.
module tb_mathb_mac_seq;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn, start, abort, result_ready;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] oper_base, coef_base;
    logic [1:0]        cfg_dataout_sel;
    logic [5:0]        cfg_mac_out_sel;
    logic              cfg_sat, cfg_rnd, cfg_tc;
    logic              busy, done, result_valid, tpram_ren;
    logic [31:0]       result;
    logic [ADDR_W-1:0] oper_raddr, coef_raddr;
    logic              mathb_clk_en, mathb_acc_clear, mathb_acc_sat, mathb_acc_rnd, mathb_tc;
    logic [5:0]        mathb_mac_out_sel;
    logic [1:0]        mathb_dataout_sel;
    logic              mathb_oper_sel, mathb_coef_sel;
    logic [31:0]       mathb_mac_out = '0;

    mathb_mac_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .EFPGA2MATHB_CLK(clk), .acc_ff_rstn(rstn), .start(start), .abort(abort), .len(len),
        .oper_base(oper_base), .coef_base(coef_base), .cfg_dataout_sel(cfg_dataout_sel),
        .cfg_mac_out_sel(cfg_mac_out_sel), .cfg_sat(cfg_sat), .cfg_rnd(cfg_rnd), .cfg_tc(cfg_tc),
        .busy(busy), .done(done), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .tpram_ren(tpram_ren), .oper_raddr(oper_raddr),
        .coef_raddr(coef_raddr), .mathb_clk_en(mathb_clk_en), .mathb_acc_clear(mathb_acc_clear),
        .mathb_acc_sat(mathb_acc_sat), .mathb_acc_rnd(mathb_acc_rnd), .mathb_tc(mathb_tc),
        .mathb_mac_out_sel(mathb_mac_out_sel), .mathb_dataout_sel(mathb_dataout_sel),
        .mathb_oper_sel(mathb_oper_sel), .mathb_coef_sel(mathb_coef_sel),
        .mathb_mac_out(mathb_mac_out)
    );

    // TPRAMs (1-cycle read), MAC accumulator and the registered output stage.
    logic [31:0] oper_mem [1024];
    logic [31:0] coef_mem [1024];
    logic [31:0] oper_rd = '0, coef_rd = '0, acc = '0;
    always @(posedge clk) begin
        if (tpram_ren) begin
            oper_rd <= oper_mem[oper_raddr];
            coef_rd <= coef_mem[coef_raddr];
        end
        if (mathb_clk_en) acc <= mathb_acc_clear ? 32'h0 : acc + oper_rd * coef_rd;
        mathb_mac_out <= acc;
    end

    typedef struct {
        logic [31:0]       res;
        int unsigned       vedge;
        int unsigned       n;
        logic [ADDR_W-1:0] ob, cb;
        logic [9:0]        cfg;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int unsigned edge_cnt = 0;
    logic [31:0] last_res = '0;
    always @(posedge clk) edge_cnt++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation when result_valid rises and audits the finished job.
    logic busy_p = 1'b0, valid_p = 1'b0;
    int unsigned ce_cnt = 0, ac_cnt = 0;
    logic [ADDR_W-1:0] oa_q[$], ca_q[$];
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] cfg_now;
        cfg_now = {mathb_acc_sat, mathb_acc_rnd, mathb_tc, mathb_mac_out_sel, mathb_dataout_sel[0]};
        if (busy && !busy_p) begin
            ce_cnt = 0; ac_cnt = 0; oa_q.delete(); ca_q.delete();
        end
        if (mathb_clk_en) ce_cnt++;
        if (mathb_acc_clear) ac_cnt++;
        if (tpram_ren) begin
            oa_q.push_back(oper_raddr);
            ca_q.push_back(coef_raddr);
        end
        if (busy && exp_q.size() > 0) chk("cfg_pins_busy", {54'd0, cfg_now}, {54'd0, exp_q[0].cfg});
        if (result_valid && !valid_p) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                chk("result", {32'd0, result}, {32'd0, e.res});
                chk("done_pulse", {63'd0, done}, 64'd1);
                chk("latency_edge", 64'(edge_cnt), 64'(e.vedge));
                chk("clk_en_cycles", 64'(ce_cnt), 64'(e.n + 1));
                chk("acc_clear_cycles", 64'(ac_cnt), 64'd1);
                chk("busy_at_valid", {63'd0, busy}, 64'd0);
                chk("cfg_pins_hold", {54'd0, cfg_now}, {54'd0, e.cfg});
                chk("read_count", 64'(oa_q.size()), 64'(e.n));
                for (int unsigned i = 0; i < e.n && i < oa_q.size(); i++) begin
                    chk("oper_raddr", 64'(oa_q[i]), 64'(ADDR_W'(e.ob + ADDR_W'(i))));
                    chk("coef_raddr", 64'(ca_q[i]), 64'(ADDR_W'(e.cb + ADDR_W'(i))));
                end
            end
        end else if (done) begin
            checks++; errors++;
            $display("FAIL spurious_done actual=1 required=0");
        end
        busy_p  = busy;
        valid_p = result_valid;
    end

    task automatic randomize_inputs;
        len             = LEN_W'($urandom);
        oper_base       = ADDR_W'($urandom);
        coef_base       = ADDR_W'($urandom);
        cfg_dataout_sel = 2'($urandom);
        cfg_mac_out_sel = 6'($urandom);
        {cfg_sat, cfg_rnd, cfg_tc} = 3'($urandom);
    endtask

    task automatic issue(input int unsigned n, input logic [ADDR_W-1:0] ob, input logic [ADDR_W-1:0] cb,
                         input logic [1:0] ds, input logic [5:0] mos, input logic s, input logic r,
                         input logic t, input bit push, input bit with_abort);
        exp_t e;
        logic [31:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < n; i++)
            sum = sum + oper_mem[ADDR_W'(ob + ADDR_W'(i))] * coef_mem[ADDR_W'(cb + ADDR_W'(i))];
        len = LEN_W'(n); oper_base = ob; coef_base = cb;
        cfg_dataout_sel = ds; cfg_mac_out_sel = mos; cfg_sat = s; cfg_rnd = r; cfg_tc = t;
        abort = with_abort;
        start = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        e.res = sum; e.vedge = edge_cnt + n + 3; e.n = n; e.ob = ob; e.cb = cb;
        e.cfg = {s, r, t, mos, ds[0]};
        if (push) begin
            exp_q.push_back(e);
            last_res = sum;
        end
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        randomize_inputs();
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned k = 0;
        while (!result_valid && k < budget) begin
            tick;
            k++;
        end
        if (!result_valid) begin
            checks++; errors++;
            $display("FAIL result_timeout actual=0 required=1");
            exp_q.delete();
        end
    endtask

    task automatic release_result(input int unsigned hold);
        repeat (hold) tick;
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        chk("valid_drop", {63'd0, result_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
        randomize_inputs();
        for (int i = 0; i < 1024; i++) begin
            oper_mem[i] = $urandom;
            coef_mem[i] = $urandom;
        end

        len = LEN_W'(2);
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            tick;
        end
        start = 1'b0;
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_ctl", 64'({busy, done, result_valid, tpram_ren, oper_raddr, coef_raddr,
                           mathb_clk_en, mathb_acc_clear, mathb_acc_sat, mathb_acc_rnd, mathb_tc,
                           mathb_mac_out_sel, mathb_dataout_sel, mathb_oper_sel, mathb_coef_sel}), 64'd0);
        rstn = 1'b1;
        tick;
        issue(2, 10'h050, 10'h060, 2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(20);
        release_result(1);

        for (int i = 0; i < 4; i++) begin
            oper_mem[10'h10 + i] = 32'(i + 1);
            coef_mem[10'h20 + i] = 32'(i + 5);
        end
        issue(4, 10'h010, 10'h020, 2'b00, 6'h15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(20);
        chk("x32_result", {32'd0, result}, 64'h46);
        release_result(2);

        oper_mem[10'h100] = 32'hFFFF_FFFF;
        coef_mem[10'h200] = 32'h1;
        issue(1, 10'h100, 10'h200, 2'b00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid(20);
        chk("len1_result", {32'd0, result}, 64'hFFFF_FFFF);
        release_result(0);

        issue(4, 10'h3FE, 10'h3FD, 2'b01, 6'h2A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_valid(20);
        release_result(1);

        // Abort during the second RUN cycle.
        issue(6, 10'h080, 10'h090, 2'b10, 6'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_clk_en", {63'd0, mathb_clk_en}, 64'd0);
        chk("abort_ren", {63'd0, tpram_ren}, 64'd0);
        chk("abort_sel", {62'd0, mathb_oper_sel, mathb_coef_sel}, 64'd0);
        chk("abort_valid", {63'd0, result_valid}, 64'd0);
        chk("abort_result", {32'd0, result}, {32'd0, last_res});
        repeat (8) tick;

        issue(3, 10'h123, 10'h321, 2'b11, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                len = LEN_W'(5);
                start = 1'b1;
            end
            tick;
            start = 1'b0;
            chk("hold_busy", {63'd0, busy}, 64'd0);
            chk("hold_ren", {63'd0, tpram_ren}, 64'd0);
            chk("hold_valid", {63'd0, result_valid}, 64'd1);
            chk("hold_result", {32'd0, result}, {32'd0, last_res});
        end
        len = LEN_W'(5);
        start = 1'b1;
        result_ready = 1'b1;
        tick;
        start = 1'b0;
        result_ready = 1'b0;
        chk("ready_valid_drop", {63'd0, result_valid}, 64'd0);
        chk("ready_start_ignored", {63'd0, busy}, 64'd0);

        len = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("len0_busy", {63'd0, busy}, 64'd0);
            chk("len0_ren", {63'd0, tpram_ren}, 64'd0);
            tick;
        end

        for (int j = 0; j < 25; j++) begin
            issue($urandom_range(1, 40), ADDR_W'($urandom), ADDR_W'($urandom), 2'($urandom),
                  6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            wait_valid(60);
            release_result($urandom_range(0, 3));
        end

        repeat (5) tick;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
